// File: rtl/div_seq_32.sv
// Sequential signed divider, non-restoring radix-2, one quotient bit per clock.
// Quotient drives LO, remainder drives HI; start/done handshake with busy stall.
module div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dzo_q, dzo_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   dext;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    q_d      = q_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dzo_d    = dzo_q;
    shifted  = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
    dext     = {1'b0, dvs_q};
    rem_step = rem_q[WIDTH] ? shifted + dext : shifted - dext;
    // Low bits suffice: the corrected remainder is in [0, |divisor|)
    rem_fix  = rem_q[WIDTH-1:0] + (rem_q[WIDTH] ? dvs_q : '0);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend[WIDTH-1] ? -dividend : dividend;
          dvs_d   = divisor[WIDTH-1] ? -divisor : divisor;
          a_d     = dividend;
          sa_d    = dividend[WIDTH-1];
          sb_d    = divisor[WIDTH-1];
          dz_d    = (divisor == '0);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = rem_step;
        q_d   = {q_q[WIDTH-2:0], ~rem_step[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = (sa_q ^ sb_q) ? -q_q : q_q;
          hi_d = sa_q ? -rem_fix : rem_fix;
        end
        dzo_d   = dz_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dzo_q   <= dzo_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = dzo_q;
  assign lo       = lo_q;
  assign hi       = hi_q;

endmodule

// File: tb/tb_div_seq_32.sv
// Directed bench for div_seq_32: vector table plus
// ignored-start and mid-operation clear sequences.
module tb_div_seq_32;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] lo;
  logic [31:0] hi;

  int checks = 0;
  int errors = 0;

  div_seq_32 dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .lo      (lo),
    .hi      (hi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] elo;
    logic [31:0] ehi;
    logic        edz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op, wait for done (bounded), check latency, results, pulse end
  task automatic run_op(input string name, input vec_t v);
    int n;
    logic busy_drop;
    @(negedge clock);
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    n         = 0;
    busy_drop = 1'b0;
    while (!done && n < 100) begin
      if (!busy) busy_drop = 1'b1;
      @(posedge clock);
      #1;
      n++;
    end
    check({name, " latency"}, 32'(n), 32'd33);
    check({name, " busy"}, {31'd0, busy_drop}, 32'd0);
    check({name, " lo"}, lo, v.elo);
    check({name, " hi"}, hi, v.ehi);
    check({name, " dz"}, {31'd0, div_zero}, {31'd0, v.edz});
    @(posedge clock);
    #1;
    check({name, " done drop"}, {30'd0, busy, done}, 32'd0);
    check({name, " lo hold"}, lo, v.elo);
  endtask

  vec_t vt[10];

  initial begin
    int n;
    int pulses;
    vec_t v;

    vt[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vt[1] = '{-32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vt[2] = '{32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2, 1'b0};
    vt[3] = '{-32'sd100, -32'sd7, 32'd14, 32'hFFFFFFFE, 1'b0};
    vt[4] = '{32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
    vt[5] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    vt[6] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
    vt[7] = '{32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0};
    vt[8] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
    vt[9] = '{32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1};

    clear    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("reset outs", {29'd0, busy, done, div_zero}, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset hi", hi, 32'd0);
    @(negedge clock);
    clear = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vt[i]);
    end

    // start with new operands during ITER must be ignored
    @(negedge clock);
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    n      = 0;
    pulses = 0;
    while (n < 45) begin
      @(posedge clock);
      #1;
      n++;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          check("ign latency", 32'(n), 32'd33);
          check("ign lo", lo, 32'd100);
          check("ign hi", hi, 32'd0);
        end
      end
      if (n == 10) begin
        dividend = 32'd7;
        divisor  = 32'd7;
        start    = 1'b1;
      end else if (n == 11) begin
        start = 1'b0;
      end
    end
    check("ign pulses", 32'(pulses), 32'd1);
    check("ign lo hold", lo, 32'd100);

    // clear mid-operation
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clock);
    end
    #1;
    clear = 1'b0;
    #1;
    check("clr outs", {30'd0, busy, done}, 32'd0);
    check("clr lo", lo, 32'd0);
    check("clr hi", hi, 32'd0);
    @(negedge clock);
    clear = 1'b1;
    v = '{32'd50, 32'd5, 32'd10, 32'd0, 1'b0};
    run_op("post clr", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq_32.md
Name: div_seq_32

Overview:
- Sequential signed 32-bit divider for the Mini SRC ALU; executes the div instruction alongside the combinational logic units.
- Quotient drives the LO register input; remainder drives the HI register input.
- Uses a non-restoring radix-2 algorithm, one quotient bit per clock.
- The control unit launches it with a start/done handshake and stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; counter width is ceil(log2(WIDTH)) + 1.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- dividend  in  WIDTH  signed two's-complement numerator (Ra).
- divisor  in  WIDTH  signed two's-complement denominator (Rb).
- busy  out  1  high from the accepting edge until done deasserts.
- done  out  1  one-cycle pulse; lo/hi/div_zero valid.
- div_zero  out  1  divisor was zero for the last operation.
- lo  out  WIDTH  quotient.
- hi  out  WIDTH  remainder.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (clock port "clock", reset port "clear").
- Reset (clear=0, asynchronous): state=IDLE; busy=0, done=0, div_zero=0, lo=0, hi=0; all internal registers cleared.
- States: IDLE, ITER, FIX, DONE.
- IDLE: on a rising edge with start=1:
  - capture |dividend| into the quotient shift register and |divisor| into the divisor register (unsigned WIDTH bits; 0x80000000 is represented exactly);
  - record the sign of dividend, the sign of divisor, and divisor==0;
  - clear the (WIDTH+1)-bit partial remainder; counter=0; go to ITER; busy=1.
- ITER: one step per edge:
  - shift {rem, q} left by 1;
  - if rem >= 0 then rem -= divisor, else rem += divisor;
  - new q LSB = ~rem_sign;
  - counter++; after WIDTH steps go to FIX.
- FIX, single edge:
  - if rem < 0, add divisor back;
  - negate the quotient if the operand signs differ; negate the remainder if the dividend is negative;
  - write lo/hi/div_zero; go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle; next edge returns to IDLE with busy=0 and done=0.
- Latency is fixed for every operand pair: done is high in the cycle following the (WIDTH+1)th edge after the start-accepting edge, i.e. 33 edges for WIDTH=32.
- Semantics: quotient truncates toward zero; remainder takes the sign of the dividend; dividend = quotient*divisor + remainder (mod 2^WIDTH).
- Divide-by-zero:
  - same latency;
  - lo=0xFFFFFFFF, hi=dividend (original signed value), div_zero=1;
  - the sign correction step is skipped.
- Overflow (-2^31 / -1): lo=0x80000000, hi=0, div_zero=0, no flag.
- Output holding:
  - lo/hi/div_zero change only at the FIX edge and hold between operations, including after done drops;
  - operand inputs are ignored outside the accepting edge and may change freely while busy.
- start while busy (ITER/FIX/DONE): ignored, no queuing; start high on the edge that leaves DONE is also ignored (only IDLE accepts).
- Back-to-back: a start held high continuously is accepted on the first IDLE edge after DONE, so throughput is one operation per WIDTH+3 cycles.
- clear asserted mid-operation: immediate return to reset values, including lo/hi; no done pulse.

Test Plan:
- 100 / 7 -> done exactly 33 edges after acceptance; lo=14, hi=2, div_zero=0, busy high throughout.
- Sign cases:
  - -100 / 7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE;
  - 100 / -7 -> lo=0xFFFFFFF2, hi=2;
  - -100 / -7 -> lo=14, hi=0xFFFFFFFE.
- 0x12345678 / 0 -> same latency; lo=0xFFFFFFFF, hi=0x12345678, div_zero=1; then 9/3 -> lo=3, hi=0, div_zero=0.
- Boundaries:
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0;
  - 0x80000000 / 1 -> lo=0x80000000, hi=0;
  - 5 / 9 -> lo=0, hi=5.
- start pulsed with new operands at ITER cycle 10 -> ignored; results match the first operation; a single done pulse.
- clear driven low at ITER cycle 15 -> busy, done, lo and hi go to 0 asynchronously; after release, start 50/5 -> lo=10, hi=0 with normal latency.
